// File: rtl/integer_formatter_pkg.sv
// rtl/integer_formatter_pkg.sv - shared widths, ASCII constants and state encoding for the integer formatter
package integer_formatter_pkg;

  localparam int CHAR_BITES          = 8;
  localparam int ATTRIBUTE_VAL_BITES = 10;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_GT    = 8'h3E;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CONVERT = 3'd1;
  localparam logic [2:0] ST_EMIT    = 3'd2;
  localparam logic [2:0] ST_TERM    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/integer_formatter_if.sv
// rtl/integer_formatter_if.sv - start/value request and character stream bundle of the integer formatter
interface integer_formatter_if
  import integer_formatter_pkg::*;
#(
  parameter int VAL_WIDTH  = ATTRIBUTE_VAL_BITES,
  parameter int CHAR_WIDTH = CHAR_BITES
);
  logic                  start;
  logic [VAL_WIDTH-1:0]  value;
  logic [CHAR_WIDTH-1:0] char;
  logic                  char_valid;
  logic                  char_ready;
  logic                  busy;
  logic                  has_finished;

  modport master (
    input  start, value, char_ready,
    output char, char_valid, busy, has_finished
  );

  modport slave (
    output start, value, char_ready,
    input  char, char_valid, busy, has_finished
  );
endinterface

// File: rtl/integer_formatter_int_to_char.sv
// rtl/integer_formatter_int_to_char.sv - combinational BCD digit to ASCII character, inverse of char_to_int
module int_to_char
  import integer_formatter_pkg::*;
#(
  parameter int CHAR_WIDTH = CHAR_BITES
) (
  input  logic [3:0]            digit,
  output logic [CHAR_WIDTH-1:0] ascii
);
  assign ascii = CHAR_WIDTH'(ASCII_ZERO) + CHAR_WIDTH'(digit);
endmodule

// File: rtl/integer_formatter.sv
// rtl/integer_formatter.sv - binary to ASCII decimal stream via serial double-dabble, MSD first, leading zeros dropped
// INTEGER_FORMATTER_TERM_EN adds a trailing space character after the last digit.
module integer_formatter
  import integer_formatter_pkg::*;
#(
  parameter int VAL_WIDTH  = ATTRIBUTE_VAL_BITES,
  parameter int CHAR_WIDTH = CHAR_BITES,
  parameter int MAX_DIGITS = 4
) (
  input logic                 clock,
  input logic                 reset,
  integer_formatter_if.master bus
);
  localparam int BCD_W = 4 * MAX_DIGITS;
  localparam int CNT_W = $clog2(VAL_WIDTH + 1);
  localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  logic [2:0]            state;
  logic [VAL_WIDTH-1:0]  val_q;
  logic [VAL_WIDTH-1:0]  val_step;
  logic [BCD_W-1:0]      bcd_q;
  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W-1:0]      bcd_step;
  logic [CNT_W-1:0]      count_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      msd_idx;
  logic [IDX_W-1:0]      sel_idx;
  logic [BCD_W-1:0]      sel_bcd;
  logic [3:0]            sel_nibble;
  logic [CHAR_WIDTH-1:0] sel_char;
  logic [CHAR_WIDTH-1:0] char_q;
  logic                  char_valid_q;
  logic                  busy_q;
  logic                  finished_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_step = {bcd_adj[BCD_W-2:0], val_q[VAL_WIDTH-1]};
  assign val_step = {val_q[VAL_WIDTH-2:0], 1'b0};

  // Highest nonzero digit of the finished conversion; all-zero leaves index 0 so "0" is still emitted.
  always_comb begin
    msd_idx = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (bcd_step[4*i +: 4] != 4'd0) msd_idx = IDX_W'(i);
    end
  end

  // The single digit converter feeds the next char register: first digit comes from the last
  // conversion step, later digits from the stored BCD one position below the current one.
  always_comb begin
    sel_bcd = bcd_q;
    sel_idx = idx_q - 1'b1;
    if (state == ST_CONVERT) begin
      sel_bcd = bcd_step;
      sel_idx = msd_idx;
    end
  end

  assign sel_nibble = sel_bcd[4*int'(sel_idx) +: 4];

  int_to_char #(.CHAR_WIDTH(CHAR_WIDTH)) u_int_to_char (
    .digit (sel_nibble),
    .ascii (sel_char)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      val_q        <= '0;
      bcd_q        <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      char_q       <= '0;
      char_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            val_q      <= bus.value;
            bcd_q      <= '0;
            count_q    <= '0;
            finished_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          bcd_q   <= bcd_step;
          val_q   <= val_step;
          count_q <= count_q + 1'b1;
          if (count_q == CNT_W'(VAL_WIDTH - 1)) begin
            idx_q        <= msd_idx;
            char_q       <= sel_char;
            char_valid_q <= 1'b1;
            state        <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (bus.char_ready) begin
            if (idx_q != '0) begin
              idx_q  <= idx_q - 1'b1;
              char_q <= sel_char;
            end else begin
`ifdef INTEGER_FORMATTER_TERM_EN
              char_q <= CHAR_WIDTH'(ASCII_SPACE);
              state  <= ST_TERM;
`else
              char_q       <= '0;
              char_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              finished_q   <= 1'b1;
              state        <= ST_DONE;
`endif
            end
          end
        end
`ifdef INTEGER_FORMATTER_TERM_EN
        ST_TERM: begin
          if (bus.char_ready) begin
            char_q       <= '0;
            char_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b1;
            state        <= ST_DONE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.char         = char_q;
  assign bus.char_valid   = char_valid_q;
  assign bus.busy         = busy_q;
  assign bus.has_finished = finished_q;

endmodule

// File: tb/tb_integer_formatter.sv
// tb/tb_integer_formatter.sv - self-checking bench for integer_formatter (table, random and corner sequences)
module tb_integer_formatter;

  logic clock = 1'b0;
  logic reset;
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  integer_formatter_if #(.VAL_WIDTH(10), .CHAR_WIDTH(8)) bus ();

  integer_formatter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

`ifdef INTEGER_FORMATTER_TERM_EN
  localparam string TERM = " ";
`else
  localparam string TERM = "";
`endif

  typedef struct {
    int unsigned value;
    int          mode;        // 0 ready always, 1 random ready, 2 five stall cycles first
    int          restart_at;  // -1: no extra start pulse
    int unsigned restart_val;
    string       expect_txt;
  } vec_t;

  vec_t tbl[$];

  task automatic check_int(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic run(input int unsigned v, input int mode, input int restart_at, input int unsigned restart_v,
                     output string got, output int lat, output int fin_lat, output int gaps,
                     output int stalls, output int stall_err);
    int   last_xfer;
    bit   hold;
    logic [7:0] hold_c;
    got = ""; lat = -1; fin_lat = -1; gaps = 0; stalls = 0; stall_err = 0;
    last_xfer = -1; hold = 1'b0; hold_c = '0;
    bus.value = 10'(v);
    bus.start = 1'b1;
    bus.char_ready = 1'b0;
    @(negedge clock);
    bus.start = 1'b0;
    check_int("busy_after_start", bus.busy, 1);
    check_int("finished_cleared", bus.has_finished, 0);
    for (int n = 0; n < 400; n++) begin
      bus.start = (n == restart_at);
      if (n == restart_at) bus.value = 10'(restart_v);
      case (mode)
        0:       bus.char_ready = 1'b1;
        1:       bus.char_ready = ($urandom_range(0, 3) != 0);
        default: bus.char_ready = !(bus.char_valid && stalls < 5);
      endcase
      if (bus.has_finished) begin
        fin_lat = n - last_xfer;
        break;
      end
      if (hold && (!bus.char_valid || bus.char !== hold_c)) stall_err++;
      if (bus.char_valid) begin
        if (lat < 0) lat = n;
        if (bus.char_ready) begin
          got = $sformatf("%s%c", got, bus.char);
          if (last_xfer >= 0 && n - last_xfer != 1) gaps++;
          last_xfer = n;
          hold = 1'b0;
        end else begin
          stalls++;
          hold = 1'b1;
          hold_c = bus.char;
        end
      end
      @(negedge clock);
    end
    bus.start = 1'b0;
    bus.char_ready = 1'b0;
  endtask

  initial begin
    string got;
    int    lat, fin_lat, gaps, stalls, stall_err, n, bad;

    tbl.push_back('{1023, 0, -1, 0,   "1023"});
    tbl.push_back('{0,    0, -1, 0,   "0"});
    tbl.push_back('{100,  0, -1, 0,   "100"});
    tbl.push_back('{7,    2, -1, 0,   "7"});
    tbl.push_back('{321,  0,  3, 999, "321"});
    tbl.push_back('{42,   0, -1, 0,   "42"});
    tbl.push_back('{10,   1, -1, 0,   "10"});
    tbl.push_back('{999,  1, -1, 0,   "999"});
    tbl.push_back('{512,  2, -1, 0,   "512"});
    tbl.push_back('{9,    0, -1, 0,   "9"});

    reset = 1'b1;
    bus.start = 1'b0;
    bus.value = '0;
    bus.char_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_int("reset_char", bus.char, 0);
    check_int("reset_valid", bus.char_valid, 0);
    check_int("reset_busy", bus.busy, 0);
    check_int("reset_finished", bus.has_finished, 0);
    reset = 1'b0;
    @(negedge clock);
    check_int("idle_busy", bus.busy, 0);

    foreach (tbl[i]) begin
      run(tbl[i].value, tbl[i].mode, tbl[i].restart_at, tbl[i].restart_val,
          got, lat, fin_lat, gaps, stalls, stall_err);
      check_str($sformatf("chars_%0d", tbl[i].value), got, {tbl[i].expect_txt, TERM});
      check_int("first_valid_latency", lat, 10);
      check_int("finish_latency", fin_lat, 1);
      check_int("stall_stability", stall_err, 0);
      check_int("done_outputs", {bus.busy, bus.char_valid, bus.char}, 0);
      if (tbl[i].mode == 0) check_int("full_rate_gaps", gaps, 0);
      if (tbl[i].mode == 2) check_int("stall_cycles", stalls, 5);
    end

    for (int r = 0; r < 40; r++) begin
      int unsigned v;
      v = $urandom_range(0, 1023);
      run(v, 1, -1, 0, got, lat, fin_lat, gaps, stalls, stall_err);
      check_str($sformatf("rand_chars_%0d", v), got, {$sformatf("%0d", v), TERM});
      check_int("rand_latency", lat, 10);
      check_int("rand_finish", fin_lat, 1);
      check_int("rand_stall_stability", stall_err, 0);
    end

    // Reset while the second digit of 1023 is on the bus.
    bus.value = 10'd1023;
    bus.char_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    n = 0;
    while (!(bus.char_valid && bus.char == 8'h30) && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_int("reach_second_digit", n, 11);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_int("abort_char", bus.char, 0);
    check_int("abort_valid", bus.char_valid, 0);
    check_int("abort_busy", bus.busy, 0);
    check_int("abort_finished", bus.has_finished, 0);
    bad = 0;
    repeat (6) begin
      @(negedge clock);
      if (bus.char_valid || bus.has_finished || bus.busy) bad++;
    end
    check_int("abort_quiet", bad, 0);
    bus.char_ready = 1'b0;

    run(56, 0, -1, 0, got, lat, fin_lat, gaps, stalls, stall_err);
    check_str("after_abort", got, {"56", TERM});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
